// File: rtl/frame_serializer.sv
// frame_serializer
// Takes parallel words over a valid/ready handshake and plays each one out as a
// framed serial stream: GAP cycles of frame reset (frame_rst=1, A=1) followed by
// WIDTH data bits on A. A one-deep holding register lets the next word queue up
// while a frame is in flight, so back-to-back frames run with no idle cycle.
module frame_serializer #(
    parameter int WIDTH     = 5,
    parameter int GAP       = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             A,
    output logic             frame_rst,
    output logic             frame_done,
    output logic             busy
);

    // Phase counter only ever counts 0..max(GAP,WIDTH)-1.
    localparam int MAX_CNT = (GAP > WIDTH) ? GAP : WIDTH;
    localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);
    localparam logic [CW-1:0] WIDTH_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hold;
    logic             r_holdValid;
    logic             r_A;
    logic             r_frameRst;
    logic             r_frameDone;
    logic             r_busy;

    state_t           w_nextState;
    logic [WIDTH-1:0] w_nextShift;
    logic [CW-1:0]    w_nextCnt;
    logic [WIDTH-1:0] w_nextHold;
    logic             w_nextHoldValid;
    logic             w_nextBit;
    logic             w_xfer;

    // Ready depends only on the holding register and reset, never on din/din_valid.
    assign din_ready  = ~r_holdValid & ~reset;
    assign w_xfer     = din_valid & din_ready;

    assign A          = r_A;
    assign frame_rst  = r_frameRst;
    assign frame_done = r_frameDone;
    assign busy       = r_busy;

    // Next-state computation for the frame sequencer and the holding register.
    always_comb begin
        w_nextState     = r_state;
        w_nextShift     = r_shift;
        w_nextCnt       = r_cnt;
        w_nextHold      = r_hold;
        w_nextHoldValid = r_holdValid;

        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_nextShift = din;
                    w_nextCnt   = '0;
                    w_nextState = SYNC;
                end
            end

            SYNC: begin
                if (w_xfer) begin
                    w_nextHold      = din;
                    w_nextHoldValid = 1'b1;
                end
                if (r_cnt == GAP_LAST) begin
                    w_nextState = SHIFT;
                    w_nextCnt   = '0;
                end else begin
                    w_nextCnt = r_cnt + 1'b1;
                end
            end

            SHIFT: begin
                if (r_cnt == WIDTH_LAST) begin
                    w_nextCnt = '0;
                    if (r_holdValid) begin
                        w_nextShift     = r_hold;
                        w_nextHoldValid = 1'b0;
                        w_nextState     = SYNC;
                    end else if (w_xfer) begin
                        w_nextShift = din;
                        w_nextState = SYNC;
                    end else begin
                        w_nextState = IDLE;
                    end
                end else begin
                    w_nextShift = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
                    w_nextCnt   = r_cnt + 1'b1;
                    if (w_xfer) begin
                        w_nextHold      = din;
                        w_nextHoldValid = 1'b1;
                    end
                end
            end

            default: begin
                w_nextState = IDLE;
            end
        endcase

        w_nextBit = MSB_FIRST ? w_nextShift[WIDTH-1] : w_nextShift[0];
    end

    // State registers plus outputs registered from the upcoming state, so every
    // output is a flop and the serial bit lines up with the SHIFT cycle it belongs to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_hold      <= '0;
            r_holdValid <= 1'b0;
            r_A         <= 1'b1;
            r_frameRst  <= 1'b1;
            r_frameDone <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_shift     <= w_nextShift;
            r_cnt       <= w_nextCnt;
            r_hold      <= w_nextHold;
            r_holdValid <= w_nextHoldValid;
            r_A         <= (w_nextState == SHIFT) ? w_nextBit : 1'b1;
            r_frameRst  <= (w_nextState != SHIFT);
            r_frameDone <= (w_nextState == SHIFT) && (w_nextCnt == WIDTH_LAST);
            r_busy      <= (w_nextState != IDLE) || w_nextHoldValid;
        end
    end

endmodule

// File: tb/tb_frame_serializer.sv
// tb_frame_serializer
// Directed bench for frame_serializer. Observed outputs are packed as
// {frame_rst, A, frame_done, din_ready, busy} and compared against hand-written
// per-cycle tables. A second instance covers GAP=2 with LSB-first ordering.
module tb_frame_serializer;

    logic       clk;
    logic       reset;
    logic [4:0] din;
    logic       dinValid;
    logic       dinReady;
    logic       a;
    logic       frameRst;
    logic       frameDone;
    logic       busy;

    logic [4:0] din2;
    logic       dinValid2;
    logic       dinReady2;
    logic       a2;
    logic       frameRst2;
    logic       frameDone2;
    logic       busy2;

    int testCount;
    int failCount;

    frame_serializer #(.WIDTH(5), .GAP(1), .MSB_FIRST(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (dinValid),
        .din_ready  (dinReady),
        .A          (a),
        .frame_rst  (frameRst),
        .frame_done (frameDone),
        .busy       (busy)
    );

    frame_serializer #(.WIDTH(5), .GAP(2), .MSB_FIRST(1'b0)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .din        (din2),
        .din_valid  (dinValid2),
        .din_ready  (dinReady2),
        .A          (a2),
        .frame_rst  (frameRst2),
        .frame_done (frameDone2),
        .busy       (busy2)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] obs1();
        return {3'b000, frameRst, a, frameDone, dinReady, busy};
    endfunction

    function automatic logic [7:0] obs2();
        return {3'b000, frameRst2, a2, frameDone2, dinReady2, busy2};
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] word, input logic valid);
        din      = word;
        dinValid = valid;
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Expected {frame_rst, A, frame_done, din_ready, busy} tables.
    localparam logic [4:0] IDLE_V = 5'b11010;
    localparam logic [4:0] RST_V  = 5'b11000;
    localparam logic [4:0] SYNC_V = 5'b11011;

    logic [4:0] sfExp [5];
    logic [4:0] bbExp [18];
    logic [4:0] seExp [5];
    logic [4:0] se2Exp [5];
    logic [4:0] freshExp [5];
    logic [4:0] lsbExp [7];
    logic [4:0] bq [3];
    int         idx;
    logic       xfer;

    initial begin
        testCount = 0;
        failCount = 0;
        // 00100, MSB first: 0,0,1,0,0
        sfExp    = '{5'b00011, 5'b00011, 5'b01011, 5'b00011, 5'b00111};
        // 10000 then held 00001 then 00000 accepted after first frame ends
        bbExp    = '{5'b11011, 5'b01001, 5'b00001, 5'b00001, 5'b00001, 5'b00101,
                     5'b11011, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b01101,
                     5'b11011, 5'b00011, 5'b00011, 5'b00011, 5'b00011, 5'b00111};
        // 11111 then 01010 (same-edge reload)
        seExp    = '{5'b01011, 5'b01011, 5'b01011, 5'b01011, 5'b01111};
        se2Exp   = '{5'b00011, 5'b01011, 5'b00011, 5'b01011, 5'b00111};
        // 10101 after mid-frame reset
        freshExp = '{5'b01011, 5'b00011, 5'b01011, 5'b00011, 5'b01111};
        // GAP=2, LSB first, 00001: two sync cycles then 1,0,0,0,0
        lsbExp   = '{5'b11011, 5'b11011, 5'b01011, 5'b00011, 5'b00011, 5'b00011, 5'b00111};
        bq       = '{5'b10000, 5'b00001, 5'b00000};

        reset     = 1'b0;
        din       = '0;
        dinValid  = 1'b0;
        din2      = '0;
        dinValid2 = 1'b0;

        // Asynchronous reset takes effect without a clock edge.
        #3 reset = 1'b1;
        #1;
        checkOutput("rst_async", obs1(), {3'b000, RST_V});
        checkOutput("rst_async2", obs2(), {3'b000, RST_V});
        @(negedge clk);
        reset = 1'b0;

        // Idle after reset for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            stepCycle();
            checkOutput("idle", obs1(), {3'b000, IDLE_V});
        end

        // Single frame.
        applyStimulus(5'b00100, 1'b1);
        stepCycle();
        applyStimulus(5'b00000, 1'b0);
        checkOutput("sf_sync", obs1(), {3'b000, SYNC_V});
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            checkOutput("sf_bit", obs1(), {3'b000, sfExp[i]});
        end
        stepCycle();
        checkOutput("sf_idle", obs1(), {3'b000, IDLE_V});

        // Back-to-back with backpressure, din_valid held while words remain.
        idx = 0;
        applyStimulus(bq[0], 1'b1);
        for (int i = 0; i < 18; i++) begin
            xfer = dinValid && dinReady;
            stepCycle();
            if (xfer) begin
                idx++;
                if (idx < 3) applyStimulus(bq[idx], 1'b1);
                else         applyStimulus(5'b00000, 1'b0);
            end
            checkOutput("b2b", obs1(), {3'b000, bbExp[i]});
        end
        checkOutput("b2b_taken", 8'(idx), 8'd3);
        stepCycle();
        checkOutput("b2b_idle", obs1(), {3'b000, IDLE_V});

        // Same-edge reload: next word offered only on the last-bit edge.
        applyStimulus(5'b11111, 1'b1);
        stepCycle();
        applyStimulus(5'b00000, 1'b0);
        checkOutput("se_sync", obs1(), {3'b000, SYNC_V});
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            checkOutput("se_bit", obs1(), {3'b000, seExp[i]});
        end
        applyStimulus(5'b01010, 1'b1);
        stepCycle();
        applyStimulus(5'b00000, 1'b0);
        checkOutput("se_reload_sync", obs1(), {3'b000, SYNC_V});
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            checkOutput("se_bit2", obs1(), {3'b000, se2Exp[i]});
        end
        stepCycle();
        checkOutput("se_idle", obs1(), {3'b000, IDLE_V});

        // Mid-frame reset with a word held.
        applyStimulus(5'b11111, 1'b1);
        stepCycle();
        applyStimulus(5'b01110, 1'b1);
        stepCycle();
        applyStimulus(5'b00000, 1'b0);
        checkOutput("mr_bit1_held", obs1(), 8'b000_01001);
        stepCycle();
        checkOutput("mr_bit2", obs1(), 8'b000_01001);
        stepCycle();
        checkOutput("mr_bit3", obs1(), 8'b000_01001);
        reset = 1'b1;
        #1;
        checkOutput("mr_reset", obs1(), {3'b000, RST_V});
        #2 reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            stepCycle();
            checkOutput("mr_idle", obs1(), {3'b000, IDLE_V});
        end
        applyStimulus(5'b10101, 1'b1);
        stepCycle();
        applyStimulus(5'b00000, 1'b0);
        checkOutput("mr_fresh_sync", obs1(), {3'b000, SYNC_V});
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            checkOutput("mr_fresh_bit", obs1(), {3'b000, freshExp[i]});
        end
        stepCycle();
        checkOutput("mr_fresh_idle", obs1(), {3'b000, IDLE_V});

        // GAP=2, LSB-first instance.
        din2      = 5'b00001;
        dinValid2 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            stepCycle();
            dinValid2 = 1'b0;
            checkOutput("lsb_gap2", obs2(), {3'b000, lsbExp[i]});
        end
        stepCycle();
        checkOutput("lsb_idle", obs2(), {3'b000, IDLE_V});

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
